// File: rtl/pipelined_brent_kung_adder.sv
// Three-stage pipelined Brent-Kung adder/subtractor with valid/ready flow control.
// S1 holds generate/propagate and the effective carry-in, S2 holds the
// up-sweep prefix result, and S3 drives the registered sum and flags.
module pipelined_brent_kung_adder #(
   parameter int WIDTH  = 16,
   parameter int EN_SUB = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             Sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Carry_out,
   output logic             Overflow,
   output logic             Zero
);

   localparam int LOG = $clog2(WIDTH);

   logic             advance;

   // Stage 1 next-state and registers
   logic             sub_eff;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] g1_d, p1_d;
   logic             c0_1_d;
   logic             v1_q;
   logic [WIDTH-1:0] g1_q, p1_q;
   logic             c0_1_q;

   // Stage 2 registers: up-sweep group terms plus the raw propagate for the sum
   logic             v2_q;
   logic [WIDTH-1:0] gg2_q, pg2_q, p2_q;
   logic             c0_2_q;

   // Stage 3 next-state and output registers
   logic [WIDTH-1:0] gg3, pg3;
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_d;
   logic             co_d, ov_d, z_d;
   logic             out_valid_q;
   logic [WIDTH-1:0] sum_q;
   logic             co_q, ov_q, z_q;

   assign advance   = ~out_valid_q | out_ready;
   assign in_ready  = advance;
   assign out_valid = out_valid_q;
   assign Sum       = sum_q;
   assign Carry_out = co_q;
   assign Overflow  = ov_q;
   assign Zero      = z_q;

   // Operand conditioning: subtract inverts B and forces the carry-in to 1
   always_comb begin
      sub_eff = (EN_SUB != 0) && Sub;
      b_eff   = B ^ {WIDTH{sub_eff}};
      g1_d    = A & b_eff;
      p1_d    = A ^ b_eff;
      c0_1_d  = sub_eff | Cin;
   end

   // Up-sweep: level l combines node i with node i-2^l where (i+1) is a multiple of 2^(l+1).
   // Each level lives in its own generate scope so no signal feeds back into itself.
   for (genvar l = 0; l < LOG; l++) begin : g_up
      logic [WIDTH-1:0] g_in, p_in, g_out, p_out;
      if (l == 0) begin : g_src
         assign g_in = g1_q;
         assign p_in = p1_q;
      end else begin : g_src
         assign g_in = g_up[l-1].g_out;
         assign p_in = g_up[l-1].p_out;
      end
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (((i + 1) % (2 ** (l + 1))) == 0) begin : g_node
            assign g_out[i] = g_in[i] | (p_in[i] & g_in[i - (2 ** l)]);
            assign p_out[i] = p_in[i] & p_in[i - (2 ** l)];
         end else begin : g_pass
            assign g_out[i] = g_in[i];
            assign p_out[i] = p_in[i];
         end
      end
   end

   // Down-sweep: fills the remaining prefixes, coarsest span first
   for (genvar k = 0; k < LOG - 1; k++) begin : g_dn
      localparam int L = LOG - 2 - k;
      logic [WIDTH-1:0] g_in, p_in, g_out, p_out;
      if (k == 0) begin : g_src
         assign g_in = gg2_q;
         assign p_in = pg2_q;
      end else begin : g_src
         assign g_in = g_dn[k-1].g_out;
         assign p_in = g_dn[k-1].p_out;
      end
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if ((((i + 1) % (2 ** (L + 1))) == (2 ** L)) && (i >= (2 ** (L + 1)))) begin : g_node
            assign g_out[i] = g_in[i] | (p_in[i] & g_in[i - (2 ** L)]);
            assign p_out[i] = p_in[i] & p_in[i - (2 ** L)];
         end else begin : g_pass
            assign g_out[i] = g_in[i];
            assign p_out[i] = p_in[i];
         end
      end
   end

   assign gg3 = g_dn[LOG-2].g_out;
   assign pg3 = g_dn[LOG-2].p_out;

   // Carries from the full prefixes, then the sum and status flags
   always_comb begin
      carry           = '0;
      carry[0]        = c0_2_q;
      carry[WIDTH:1]  = gg3 | (pg3 & {WIDTH{c0_2_q}});
      sum_d           = p2_q ^ carry[WIDTH-1:0];
      co_d            = carry[WIDTH];
      ov_d            = carry[WIDTH] ^ carry[WIDTH-1];
      z_d             = ~|sum_d;
   end

   // Pipeline registers: every stage shifts together on advance and freezes otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q        <= 1'b0;
         g1_q        <= '0;
         p1_q        <= '0;
         c0_1_q      <= 1'b0;
         v2_q        <= 1'b0;
         gg2_q       <= '0;
         pg2_q       <= '0;
         p2_q        <= '0;
         c0_2_q      <= 1'b0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         co_q        <= 1'b0;
         ov_q        <= 1'b0;
         z_q         <= 1'b0;
      end else if (advance) begin
         v1_q        <= in_valid;
         g1_q        <= g1_d;
         p1_q        <= p1_d;
         c0_1_q      <= c0_1_d;
         v2_q        <= v1_q;
         gg2_q       <= g_up[LOG-1].g_out;
         pg2_q       <= g_up[LOG-1].p_out;
         p2_q        <= p1_q;
         c0_2_q      <= c0_1_q;
         out_valid_q <= v2_q;
         sum_q       <= sum_d;
         co_q        <= co_d;
         ov_q        <= ov_d;
         z_q         <= z_d;
      end
   end

endmodule

// File: tb/tb_pipelined_brent_kung_adder.sv
// Bench for pipelined_brent_kung_adder: six instances (WIDTH 8/16/32 x EN_SUB 0/1)
// share one stimulus bus; only the selected instance sees in_valid, the others drain.
module tb_pipelined_brent_kung_adder;

   localparam int NDUT  = 6;
   localparam int K16   = 3;   // WIDTH 16, EN_SUB 1
   localparam int K16NS = 2;   // WIDTH 16, EN_SUB 0

   typedef struct {
      longint unsigned s;
      bit co, ov, z;
   } res_t;

   typedef struct {
      longint unsigned a, b;
      bit cin, sub;
      longint unsigned s;
      bit co, ov, z;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] a_t, b_t;
   logic        cin_t, sub_t, in_valid_t, out_ready_t;
   int          sel;

   logic        rdy_w [NDUT];
   logic        ovld_w[NDUT];
   logic        co_w  [NDUT];
   logic        ovf_w [NDUT];
   logic        z_w   [NDUT];
   logic [63:0] sum_w [NDUT];

   logic        rdy, ovld, co, ovf, zf;
   logic [63:0] sum;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < NDUT; k++) begin : g_dut
      localparam int W = 8 << (k / 2);
      logic [W-1:0] s;
      pipelined_brent_kung_adder #(.WIDTH(W), .EN_SUB(k % 2)) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_valid (in_valid_t && (sel == k)),
         .in_ready (rdy_w[k]),
         .A        (a_t[W-1:0]),
         .B        (b_t[W-1:0]),
         .Cin      (cin_t),
         .Sub      (sub_t),
         .out_valid(ovld_w[k]),
         .out_ready(out_ready_t || (sel != k)),
         .Sum      (s),
         .Carry_out(co_w[k]),
         .Overflow (ovf_w[k]),
         .Zero     (z_w[k])
      );
      assign sum_w[k] = 64'(s);
   end

   assign rdy  = rdy_w[sel];
   assign ovld = ovld_w[sel];
   assign co   = co_w[sel];
   assign ovf  = ovf_w[sel];
   assign zf   = z_w[sel];
   assign sum  = sum_w[sel];

   // Reference: plain integer arithmetic on unsigned and signed interpretations
   function automatic void model(input int w, input bit en, input longint unsigned a_in,
                                 input longint unsigned b_in, input bit cin, input bit sub,
                                 output res_t r);
      longint unsigned mask, a, b, t;
      longint sa, sb, sr, lim;
      mask = (64'd1 << w) - 64'd1;
      lim  = longint'(64'd1 << (w - 1));
      a    = a_in & mask;
      b    = b_in & mask;
      sa   = longint'(a);
      sb   = longint'(b);
      if (sa >= lim) sa = sa - 2 * lim;
      if (sb >= lim) sb = sb - 2 * lim;
      if (en && sub) begin
         t    = (a - b) & mask;
         r.co = (a >= b);
         sr   = sa - sb;
      end else begin
         t    = a + b + longint'(cin);
         r.co = (t > mask);
         t    = t & mask;
         sr   = sa + sb + longint'(cin);
      end
      r.ov = (sr >= lim) || (sr < -lim);
      r.s  = t;
      r.z  = (t == 0);
   endfunction

   // Launch one operation now and wait for its result; lat counts rising edges
   task automatic run_op(input longint unsigned a, input longint unsigned b, input bit cin,
                         input bit sub, output res_t r, output int lat);
      a_t = a; b_t = b; cin_t = cin; sub_t = sub;
      in_valid_t = 1'b1; out_ready_t = 1'b1;
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         in_valid_t = 1'b0;
         a_t = {$urandom, $urandom};
         b_t = {$urandom, $urandom};
         #1;
         if (ovld) break;
      end
      r.s = sum; r.co = co; r.ov = ovf; r.z = zf;
   endtask

   task automatic test_reset();
      out_ready_t = 1'b0;
      #2;
      total++; if (ovld !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", ovld); else passed++;
      total++; if (sum !== 64'h0) $display("FAIL reset_sum: got %h expected 0", sum); else passed++;
      total++; if ({co, ovf, zf} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {co, ovf, zf}); else passed++;
      total++; if (rdy !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", rdy); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      out_ready_t = 1'b1;
   endtask

   task automatic test_vectors();
      vec_t v[6];
      res_t r;
      int lat;
      v[0] = '{64'hFFFF, 64'h0001, 1'b0, 1'b0, 64'h0000, 1'b1, 1'b0, 1'b1};
      v[1] = '{64'h7FFF, 64'h0001, 1'b0, 1'b0, 64'h8000, 1'b0, 1'b1, 1'b0};
      v[2] = '{64'h0001, 64'h0003, 1'b1, 1'b0, 64'h0005, 1'b0, 1'b0, 1'b0};
      v[3] = '{64'h0005, 64'h0007, 1'b1, 1'b1, 64'hFFFE, 1'b0, 1'b0, 1'b0};
      v[4] = '{64'h0007, 64'h0005, 1'b0, 1'b1, 64'h0002, 1'b1, 1'b0, 1'b0};
      v[5] = '{64'h8000, 64'h0001, 1'b0, 1'b1, 64'h7FFF, 1'b1, 1'b1, 1'b0};
      sel = K16;
      for (int i = 0; i < 6; i++) begin
         run_op(v[i].a, v[i].b, v[i].cin, v[i].sub, r, lat);
         total++;
         if (lat !== 3) $display("FAIL vec%0d_latency: got %0d expected 3", i, lat); else passed++;
         total++;
         if ({r.s, r.co, r.ov, r.z} !== {v[i].s, v[i].co, v[i].ov, v[i].z})
            $display("FAIL vec%0d_result: got sum=%h c=%b v=%b z=%b expected sum=%h c=%b v=%b z=%b",
                     i, r.s, r.co, r.ov, r.z, v[i].s, v[i].co, v[i].ov, v[i].z);
         else passed++;
      end
   endtask

   task automatic test_en_sub0();
      res_t r;
      int lat;
      sel = K16NS;
      run_op(64'h0007, 64'h0005, 1'b0, 1'b1, r, lat);
      total++;
      if ({r.s, r.co, r.ov, r.z} !== {64'h000C, 1'b0, 1'b0, 1'b0} || lat !== 3)
         $display("FAIL en_sub0_ignores_sub: got sum=%h c=%b lat=%0d expected sum=000c c=0 lat=3", r.s, r.co, lat);
      else passed++;
      sel = K16;
   endtask

   task automatic test_backpressure();
      longint unsigned ins[4] = '{1, 2, 3, 4};
      int ptr = 0;
      int optr = 0;
      sel = K16;
      in_valid_t = 1'b0;
      @(negedge clk);
      for (int c = 0; c < 16; c++) begin
         out_ready_t = !(c >= 3 && c <= 6);
         in_valid_t  = (ptr < 4);
         if (ptr < 4) begin
            a_t = ins[ptr]; b_t = ins[ptr]; cin_t = 1'b0; sub_t = 1'b0;
         end
         #1;
         if (c >= 3 && c <= 6) begin
            total++;
            if (rdy !== 1'b0) $display("FAIL bp_in_ready_c%0d: got %b expected 0", c, rdy); else passed++;
            total++;
            if (ovld !== 1'b1 || sum !== 64'h2)
               $display("FAIL bp_hold_c%0d: got valid=%b sum=%h expected valid=1 sum=0002", c, ovld, sum);
            else passed++;
         end
         if (ovld && out_ready_t) begin
            total++;
            if (optr >= 4 || sum !== 64'(2 * (optr + 1)))
               $display("FAIL bp_order_%0d: got %h expected %h", optr, sum, 64'(2 * (optr + 1)));
            else passed++;
            optr++;
         end
         if (in_valid_t && rdy) ptr++;
         @(negedge clk);
      end
      in_valid_t = 1'b0;
      total++;
      if (optr !== 4) $display("FAIL bp_count: got %0d results expected 4", optr); else passed++;
   endtask

   task automatic test_back_to_back();
      res_t e[8];
      sel = K16;
      in_valid_t = 1'b0;
      out_ready_t = 1'b1;
      repeat (4) @(negedge clk);
      for (int c = 0; c < 11; c++) begin
         in_valid_t = (c < 8);
         if (c < 8) begin
            a_t = {$urandom, $urandom}; b_t = {$urandom, $urandom};
            cin_t = 1'($urandom_range(1)); sub_t = 1'($urandom_range(1));
            model(16, 1'b1, a_t, b_t, cin_t, sub_t, e[c]);
         end
         #1;
         if (c >= 3) begin
            total++;
            if (ovld !== 1'b1 || {sum, co, ovf, zf} !== {e[c-3].s, e[c-3].co, e[c-3].ov, e[c-3].z})
               $display("FAIL b2b_%0d: got valid=%b sum=%h c=%b v=%b z=%b expected valid=1 sum=%h c=%b v=%b z=%b",
                        c - 3, ovld, sum, co, ovf, zf, e[c-3].s, e[c-3].co, e[c-3].ov, e[c-3].z);
            else passed++;
         end
         @(negedge clk);
      end
      in_valid_t = 1'b0;
   endtask

   task automatic test_reset_midflight();
      res_t r;
      int lat;
      int extra = 0;
      sel = K16;
      out_ready_t = 1'b1;
      in_valid_t = 1'b0;
      @(negedge clk);
      a_t = 64'h1; b_t = 64'h1; cin_t = 1'b0; sub_t = 1'b0; in_valid_t = 1'b1;
      @(negedge clk);
      a_t = 64'h2; b_t = 64'h2;
      @(negedge clk);
      in_valid_t = 1'b0;
      rst_n = 1'b0;
      #1;
      total++;
      if (ovld !== 1'b0 || sum !== 64'h0 || rdy !== 1'b1)
         $display("FAIL midrst_async_clear: got valid=%b sum=%h ready=%b expected 0 0000 1", ovld, sum, rdy);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      run_op(64'h0010, 64'h0020, 1'b0, 1'b0, r, lat);
      total++;
      if (lat !== 3 || r.s !== 64'h0030)
         $display("FAIL midrst_next_op: got sum=%h lat=%0d expected sum=0030 lat=3", r.s, lat);
      else passed++;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #1;
         if (ovld) extra++;
      end
      total++;
      if (extra !== 0) $display("FAIL midrst_no_stale: got %0d extra results expected 0", extra); else passed++;
   endtask

   task automatic test_random(input int k, input int n);
      res_t q[$];
      res_t e, r;
      int   w, sent, got, cyc;
      bit   en;
      w = 8 << (k / 2);
      en = 1'(k % 2);
      sent = 0; got = 0; cyc = 0;
      sel = k;
      @(negedge clk);
      while ((sent < n || got < n) && cyc < n * 8 + 200) begin
         in_valid_t  = (sent < n) && ($urandom_range(3) != 0);
         a_t = {$urandom, $urandom};
         b_t = {$urandom, $urandom};
         if ($urandom_range(7) == 0) a_t = '1;
         if ($urandom_range(7) == 0) b_t = 64'(1) << (w - 1);
         cin_t = 1'($urandom_range(1));
         sub_t = 1'($urandom_range(1));
         out_ready_t = ($urandom_range(3) != 0);
         #1;
         if (ovld && out_ready_t) begin
            total++;
            if (q.size() == 0) begin
               $display("FAIL rand_k%0d_unexpected: got sum=%h expected no result", k, sum);
            end else begin
               e = q.pop_front();
               if ({sum, co, ovf, zf} !== {e.s, e.co, e.ov, e.z})
                  $display("FAIL rand_k%0d_%0d: got sum=%h c=%b v=%b z=%b expected sum=%h c=%b v=%b z=%b",
                           k, got, sum, co, ovf, zf, e.s, e.co, e.ov, e.z);
               else passed++;
            end
            got++;
         end
         if (in_valid_t && rdy) begin
            model(w, en, a_t, b_t, cin_t, sub_t, r);
            q.push_back(r);
            sent++;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid_t = 1'b0;
      out_ready_t = 1'b1;
      total++;
      if (got != n || q.size() != 0)
         $display("FAIL rand_k%0d_complete: got %0d results (%0d pending) expected %0d", k, got, q.size(), n);
      else passed++;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      sel = K16;
      rst_n = 1'b0;
      in_valid_t = 1'b0;
      out_ready_t = 1'b1;
      a_t = '0; b_t = '0; cin_t = 1'b0; sub_t = 1'b0;
      test_reset();
      test_vectors();
      test_en_sub0();
      test_backpressure();
      test_back_to_back();
      test_reset_midflight();
      for (int k = 0; k < NDUT; k++) test_random(k, (k == K16) ? 10000 : 3000);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
